// File: rtl/syn_fifo_prog.sv
// rtl/syn_fifo_prog.sv - synchronous FIFO with programmable almost-full/empty thresholds
// Standard or first-word-fall-through read; sticky overflow/underflow; synchronous flush.
module syn_fifo_prog #(
  parameter int FIFO_ENTRIES = 16,
  parameter int DATA_WIDTH   = 18,
  parameter bit FWFT         = 1'b0,
  parameter int AF_DEFAULT   = FIFO_ENTRIES - 2,
  parameter int AE_DEFAULT   = 2,
  localparam int CW          = $clog2(FIFO_ENTRIES) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic                  rd_i,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  valid_o,
  input  logic                  cfg_we_i,
  input  logic [CW-1:0]         cfg_af_i,
  input  logic [CW-1:0]         cfg_ae_i,
  output logic [CW-1:0]         count_o,
  output logic                  fifo_full_o,
  output logic                  fifo_empty_o,
  output logic                  half_full_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int AW = CW - 1;

  if ((FIFO_ENTRIES < 4) || ((FIFO_ENTRIES & (FIFO_ENTRIES - 1)) != 0)) begin : g_bad_depth
    $error("syn_fifo_prog: FIFO_ENTRIES must be a power of two and at least 4");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_ENTRIES];
  logic [CW-1:0]         wr_ptr, rd_ptr, count, af_q, ae_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  valid_q, ovf_q, unf_q;
  logic                  ptr_full, ptr_empty, wr_acc, rd_acc;

  // Extra pointer MSB distinguishes a full ring from an empty one.
  assign ptr_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign ptr_empty = (wr_ptr == rd_ptr);
  assign wr_acc    = wr_i && !ptr_full;
  assign rd_acc    = rd_i && !ptr_empty;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      af_q    <= CW'(AF_DEFAULT);
      ae_q    <= CW'(AE_DEFAULT);
    end else if (clr_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (cfg_we_i) begin
        af_q <= cfg_af_i;
        ae_q <= cfg_ae_i;
      end
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout_q <= mem[rd_ptr[AW-1:0]];
      end
      if (wr_acc && !rd_acc) count <= count + 1'b1;
      else if (rd_acc && !wr_acc) count <= count - 1'b1;
      if (wr_i && ptr_full) ovf_q <= 1'b1;
      if (rd_i && ptr_empty) unf_q <= 1'b1;
      valid_q <= rd_acc;
    end
  end

  // Storage is deliberately not reset or flushed; only the pointers define contents.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && !clr_i && wr_acc) mem[wr_ptr[AW-1:0]] <= data_in_i;
  end

  assign count_o        = count;
  assign fifo_full_o    = (count == CW'(FIFO_ENTRIES));
  assign fifo_empty_o   = (count == '0);
  assign half_full_o    = (count >= CW'(FIFO_ENTRIES / 2));
  assign almost_full_o  = (count >= af_q);
  assign almost_empty_o = (count <= ae_q);
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

  assign data_out_o = FWFT ? (fifo_empty_o ? '0 : mem[rd_ptr[AW-1:0]]) : dout_q;
  assign valid_o    = FWFT ? !fifo_empty_o : valid_q;

endmodule

// File: tb/tb_syn_fifo_prog.sv
// tb/tb_syn_fifo_prog.sv - self-checking bench for syn_fifo_prog (standard and FWFT instances)
module tb_syn_fifo_prog;
  localparam int N = 8, DW = 8, CW = 4;

  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, wr = 1'b0, rd = 1'b0, cfg_we = 1'b0;
  logic [DW-1:0] din = '0;
  logic [CW-1:0] cfg_af = '0, cfg_ae = '0;

  logic [DW-1:0] dout0, dout1;
  logic [CW-1:0] cnt0, cnt1;
  logic v0, full0, empty0, half0, af0, ae0, ovf0, unf0;
  logic v1, full1, empty1, half1, af1, ae1, ovf1, unf1;

  syn_fifo_prog #(.FIFO_ENTRIES(N), .DATA_WIDTH(DW), .FWFT(1'b0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .wr_i(wr), .data_in_i(din), .rd_i(rd),
    .data_out_o(dout0), .valid_o(v0), .cfg_we_i(cfg_we), .cfg_af_i(cfg_af), .cfg_ae_i(cfg_ae),
    .count_o(cnt0), .fifo_full_o(full0), .fifo_empty_o(empty0), .half_full_o(half0),
    .almost_full_o(af0), .almost_empty_o(ae0), .overflow_o(ovf0), .underflow_o(unf0));

  syn_fifo_prog #(.FIFO_ENTRIES(N), .DATA_WIDTH(DW), .FWFT(1'b1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .wr_i(wr), .data_in_i(din), .rd_i(rd),
    .data_out_o(dout1), .valid_o(v1), .cfg_we_i(cfg_we), .cfg_af_i(cfg_af), .cfg_ae_i(cfg_ae),
    .count_o(cnt1), .fifo_full_o(full1), .fifo_empty_o(empty1), .half_full_o(half1),
    .almost_full_o(af1), .almost_empty_o(ae1), .overflow_o(ovf1), .underflow_o(unf1));

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    int            exp_count;
    logic          exp_valid;
    logic [DW-1:0] exp_dout;
  } vec_t;

  int passed = 0, total = 0;
  int m_cnt = 0, m_af = N - 2, m_ae = 2;
  bit m_ovf = 0, m_unf = 0;
  logic [DW-1:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 32'(cnt0), 32'(m_cnt));
    chk({tag, "_count_fwft"}, 32'(cnt1), 32'(m_cnt));
    chk({tag, "_full"}, 32'(full0), 32'(m_cnt == N));
    chk({tag, "_empty"}, 32'(empty0), 32'(m_cnt == 0));
    chk({tag, "_half"}, 32'(half0), 32'(m_cnt >= N / 2));
    chk({tag, "_afull"}, 32'(af0), 32'(m_cnt >= m_af));
    chk({tag, "_aempty"}, 32'(ae0), 32'(m_cnt <= m_ae));
    chk({tag, "_ovf"}, 32'(ovf0), 32'(m_ovf));
    chk({tag, "_unf"}, 32'(unf0), 32'(m_unf));
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ovf = 0; m_unf = 0; m_af = N - 2; m_ae = 2;
    sb.delete();
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge state.
  task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d, output logic [DW-1:0] rdata);
    bit wacc, racc;
    wr = w; rd = r; din = d;
    chk("fwft_valid", 32'(v1), 32'(m_cnt != 0));
    if (m_cnt != 0) chk("fwft_data", 32'(dout1), 32'(sb[0]));
    wacc = w && (m_cnt != N);
    racc = r && (m_cnt != 0);
    if (w && !wacc) m_ovf = 1;
    if (r && !racc) m_unf = 1;
    if (wacc) sb.push_back(d);
    m_cnt = m_cnt + int'(wacc) - int'(racc);
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
    chk("std_valid", 32'(v0), 32'(racc));
    rdata = dout0;
    if (racc) chk("std_data", 32'(dout0), 32'(sb.pop_front()));
    check_state("cyc");
  endtask

  task automatic clr_cyc();
    clr = 1'b1; wr = 1'b1; rd = 1'b1; din = 8'hEE;
    cfg_we = 1'b1; cfg_af = 4'd0; cfg_ae = 4'd7;
    @(posedge clk); #1;
    clr = 1'b0; wr = 1'b0; rd = 1'b0; cfg_we = 1'b0;
    m_cnt = 0; m_ovf = 0; m_unf = 0;
    sb.delete();
    chk("clr_valid", 32'(v0), 32'd0);
    check_state("clr");
  endtask

  task automatic cfg_cyc(input int af, input int ae);
    cfg_we = 1'b1; cfg_af = CW'(af); cfg_ae = CW'(ae);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_af = af; m_ae = ae;
    chk("cfg_valid", 32'(v0), 32'd0);
    check_state("cfg");
  endtask

  initial begin
    vec_t tbl[17];
    logic [DW-1:0] rdata;

    for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 1'b0, DW'(i + 1), i + 1, 1'b0, '0};
    for (int i = 0; i < 8; i++) tbl[8 + i] = '{1'b0, 1'b1, '0, 7 - i, 1'b1, DW'(i + 1)};
    tbl[16] = '{1'b1, 1'b1, 8'h55, 1, 1'b0, '0};

    #12;
    chk("rst_dout", 32'(dout0), 32'd0);
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_valid_fwft", 32'(v1), 32'd0);
    chk("rst_dout_fwft", 32'(dout1), 32'd0);
    check_state("rst");
    @(negedge clk); rst_n = 1'b1;

    // Fill/drain and empty write+read collision.
    foreach (tbl[i]) begin
      cyc(tbl[i].wr, tbl[i].rd, tbl[i].din, rdata);
      chk("tbl_count", 32'(cnt0), 32'(tbl[i].exp_count));
      chk("tbl_valid", 32'(v0), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) chk("tbl_dout", 32'(rdata), 32'(tbl[i].exp_dout));
    end
    chk("empty_wr_rd_unf", 32'(unf0), 32'd1);
    chk("fwft_first_valid", 32'(v1), 32'd1);
    chk("fwft_first_data", 32'(dout1), 32'h55);

    // Full with write+read: write rejected, 0xAA never appears.
    clr_cyc();
    for (int i = 0; i < N; i++) cyc(1'b1, 1'b0, DW'(8'h10 + i), rdata);
    cyc(1'b1, 1'b1, 8'hAA, rdata);
    chk("full_wr_rd_count", 32'(cnt0), 32'd7);
    chk("full_wr_rd_ovf", 32'(ovf0), 32'd1);
    for (int i = 0; i < N - 1; i++) begin
      cyc(1'b0, 1'b1, '0, rdata);
      chk("no_aa_readback", 32'(rdata != 8'hAA), 32'd1);
    end

    // Streaming at depth 3 across pointer wrap.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, DW'(8'h40 + i), rdata);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, DW'($urandom), rdata);
    chk("stream_count", 32'(cnt0), 32'd3);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, '0, rdata);

    // Thresholds, out-of-range thresholds and clear.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, DW'(8'h60 + i), rdata);
    chk("af_before_cfg", 32'(af0), 32'd0);
    cfg_cyc(4, 1);
    chk("af_after_cfg", 32'(af0), 32'd1);
    clr_cyc();
    cyc(1'b1, 1'b0, 8'h70, rdata);
    chk("ae_kept_after_clr", 32'(ae0), 32'd1);
    cyc(1'b1, 1'b0, 8'h71, rdata);
    chk("ae_drop_at_2", 32'(ae0), 32'd0);
    cfg_cyc(0, 8);
    chk("af_zero_forced", 32'(af0), 32'd1);
    chk("ae_big_forced", 32'(ae0), 32'd1);
    clr_cyc();
    cfg_cyc(6, 2);

    // Asynchronous reset mid-burst at count 5.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DW'(8'h30 + i), rdata);
    wr = 1'b1; din = 8'h99;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_dout", 32'(dout0), 32'd0);
    chk("arst_valid", 32'(v0), 32'd0);
    chk("arst_valid_fwft", 32'(v1), 32'd0);
    check_state("arst");
    wr = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    cyc(1'b0, 1'b1, '0, rdata);
    chk("post_rst_unf", 32'(unf0), 32'd1);
    cyc(1'b1, 1'b0, 8'h5A, rdata);
    cyc(1'b0, 1'b1, '0, rdata);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/syn_fifo_prog.md
SYN_FIFO_PROG -- requirements
Module: syn_fifo_prog

Interface
REQ-001 The block SHALL have parameter FIFO_ENTRIES, default 16: storage depth; power of two, minimum 4.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 18: data word width.
REQ-003 The block SHALL have parameter FWFT, default 0: 0 = standard read mode, 1 = first-word-fall-through mode.
REQ-004 The block SHALL have parameters AF_DEFAULT, default FIFO_ENTRIES-2, and AE_DEFAULT, default 2: reset values of the almost-full and almost-empty thresholds.
REQ-005 The ports SHALL be exactly as follows, with CW = $clog2(FIFO_ENTRIES)+1:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- clr_i  in  1  synchronous flush.
- wr_i  in  1  write request.
- data_in_i  in  DATA_WIDTH  write data.
- rd_i  in  1  read request (pop).
- data_out_o  out  DATA_WIDTH  read data.
- valid_o  out  1  data_out_o holds valid data.
- cfg_we_i  in  1  load thresholds.
- cfg_af_i  in  CW  almost-full threshold.
- cfg_ae_i  in  CW  almost-empty threshold.
- count_o  out  CW  stored word count, 0..FIFO_ENTRIES.
- fifo_full_o  out  1  count == FIFO_ENTRIES.
- fifo_empty_o  out  1  count == 0.
- half_full_o  out  1  count >= FIFO_ENTRIES/2.
- almost_full_o  out  1  count >= AF threshold.
- almost_empty_o  out  1  count <= AE threshold.
- overflow_o  out  1  sticky: a write was rejected.
- underflow_o  out  1  sticky: a read was rejected.
REQ-006 Elaboration SHALL fail with $error if FIFO_ENTRIES is not a power of two or is below 4.

Function
REQ-007 Write and read pointers SHALL be CW bits wide. Full and empty SHALL be resolved by the pointer MSB difference plus equality of the lower bits. count_o SHALL be a registered counter held consistent with the pointers.
REQ-008 A write SHALL be accepted iff wr_i=1 and fifo_full_o=0, evaluated on the pre-edge state. On acceptance, data_in_i is stored at the write pointer and the write pointer increments, wrapping modulo 2*FIFO_ENTRIES.
REQ-009 A read SHALL be accepted iff rd_i=1 and fifo_empty_o=0, evaluated on the pre-edge state. On acceptance, the read pointer increments.
REQ-010 Simultaneous accepted read and write SHALL leave count_o unchanged and advance both pointers.
REQ-011 When full and wr_i=rd_i=1, the read SHALL be accepted, the write rejected, and overflow_o set.
REQ-012 When empty and wr_i=rd_i=1, the write SHALL be accepted, the read rejected, and underflow_o set.
REQ-013 overflow_o and underflow_o SHALL remain set until clr_i or reset.
REQ-014 Standard mode (FWFT=0): an accepted read SHALL register the head word into data_out_o at the accepting edge, with valid_o=1 for exactly the following cycle. data_out_o SHALL hold its value until the next accepted read.
REQ-015 FWFT mode (FWFT=1): data_out_o SHALL show the head word combinationally, with valid_o = ~fifo_empty_o. An accepted read exposes the next word in the following cycle. Read latency from the first write SHALL be 1 cycle.
REQ-016 All status flags SHALL derive combinationally from the registered count_o and thresholds only, never from wr_i or rd_i. Flags therefore change in the cycle after the accepting edge.
REQ-017 cfg_we_i=1 SHALL load cfg_af_i and cfg_ae_i into the threshold registers at the edge. New thresholds take effect in the next cycle. Pointers and data SHALL be unaffected.
REQ-018 Out-of-range thresholds SHALL NOT be clamped: AF=0 forces almost_full_o=1, and AE >= FIFO_ENTRIES forces almost_empty_o=1.
REQ-019 clr_i=1 SHALL have priority over wr_i, rd_i and cfg_we_i. It zeroes pointers, count_o, overflow_o, underflow_o and valid_o; retains thresholds; and does not clear memory contents.

Reset
REQ-020 rst_n_i=0 SHALL asynchronously force:
- pointers, count_o and data_out_o to 0;
- valid_o, overflow_o and underflow_o to 0;
- thresholds to AF_DEFAULT/AE_DEFAULT.
REQ-021 Under REQ-020, the flags SHALL follow from count_o=0: fifo_empty_o=1, almost_empty_o=1, all other flags 0.
REQ-022 Reset mid-operation SHALL discard all stored words. Memory array contents SHALL NOT be reset.
REQ-023 Deassertion of rst_n_i SHALL be synchronous to clk_i externally. No operation is accepted on the deassertion edge.

Verification (FIFO_ENTRIES=8, DATA_WIDTH=8)
REQ-024 Fill/drain, FWFT=0:
- Write 0x01..0x08 -> after the 8th edge, fifo_full_o=1, count_o=8, almost_full_o=1 (from count_o=6).
- Read 8 -> data_out_o 0x01..0x08 in order, each with a one-cycle valid_o; then fifo_empty_o=1.
REQ-025 Full with wr_i=rd_i=1, data_in_i=0xAA -> count_o becomes 7, overflow_o=1, 0xAA never read back.
REQ-026 Empty with wr_i=rd_i=1, data_in_i=0x55 -> count_o=1, underflow_o=1. FWFT=1: data_out_o=0x55 with valid_o=1 the next cycle.
REQ-027 Wrap-around: run 20 cycles of a continuous write+read stream at count_o=3 -> count_o stays 3, output order preserved across pointer wrap.
REQ-028 Thresholds and clear:
- cfg_we_i with cfg_af_i=4 and cfg_ae_i=1 at count_o=4 -> almost_full_o=1 the next cycle.
- clr_i=1 -> count_o=0, fifo_empty_o=1, sticky errors 0, thresholds still 4/1.
REQ-029 Assert rst_n_i=0 mid-burst at count_o=5 -> outputs match REQ-020/REQ-021 immediately, without waiting for a clock edge.
